pe_xconnect_rx: RTL and testbench

//  PE-side receive port for the crossbar return path. Captures words the xconnect

---
 rtl/pe_xconnect_rx.sv | 106 ++++++++++
 tb/tb_pe_xconnect_rx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_xconnect_rx.sv
// PE-side crossbar receive port: filters words by destination, buffers them with source index in a FWFT FIFO.
// Optional build macro PE_RX_DROP_CNT_EN adds the saturating drop_count output.
module pe_xconnect_rx #(
   parameter int WORD_SIZE  = 256,
   parameter int NOF_PES    = 16,
   parameter int FIFO_DEPTH = 4
`ifdef PE_RX_DROP_CNT_EN
   ,parameter int CNT_W     = 16
`endif
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [$clog2(NOF_PES)-1:0]      my_pe_index,
   input  logic                            xc_valid,
   input  logic [WORD_SIZE-1:0]            xc_data,
   input  logic [$clog2(NOF_PES)-1:0]      xc_src_pe_index,
   input  logic [$clog2(NOF_PES)-1:0]      xc_dest_pe_index,
   output logic                            pe_valid,
   input  logic                            pe_ready,
   output logic [WORD_SIZE-1:0]            pe_data,
   output logic [$clog2(NOF_PES)-1:0]      pe_src_pe_index,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow
`ifdef PE_RX_DROP_CNT_EN
   ,output logic [CNT_W-1:0]               drop_count
`endif
);

   localparam int NOF_LEVELS = $clog2(NOF_PES);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int LVL_W      = PTR_W + 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

   logic [WORD_SIZE-1:0]  data_q [FIFO_DEPTH];
   logic [NOF_LEVELS-1:0] src_q  [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  ovf_q, ovf_d;
   logic                  match, pop, push, drop;

   // Full/empty come from the level counter; pointers alone are ambiguous when equal.
   always_comb begin
      match    = xc_valid && (xc_dest_pe_index == my_pe_index);
      pop      = (level_q != '0) && pe_ready;
      push     = match && ((level_q != DEPTH_L) || pop);
      drop     = match && !push;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop)
         level_d = level_q + LVL_W'(1);
      else if (pop && !push)
         level_d = level_q - LVL_W'(1);
      ovf_d    = ovf_q || drop;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i] <= '0;
            src_q[i]  <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         if (push) begin
            data_q[wr_ptr_q] <= xc_data;
            src_q[wr_ptr_q]  <= xc_src_pe_index;
         end
      end
   end

   // No bypass: the head is always read from storage, giving one cycle of latency.
   assign pe_valid        = (level_q != '0);
   assign pe_data         = data_q[rd_ptr_q];
   assign pe_src_pe_index = src_q[rd_ptr_q];
   assign fifo_level      = level_q;
   assign overflow        = ovf_q;

`ifdef PE_RX_DROP_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (drop && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign drop_count = cnt_q;
`endif

endmodule

// File: tb/tb_pe_xconnect_rx.sv
// Self-checking bench for pe_xconnect_rx: per-scenario tasks plus a queue scoreboard checked at every negedge.
module tb_pe_xconnect_rx;

   localparam int WORD_SIZE  = 256;
   localparam int NOF_PES    = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int NL         = $clog2(NOF_PES);
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef PE_RX_DROP_CNT_EN
   localparam int CNT_W      = 16;
`endif

   typedef struct packed {
      logic [NL-1:0]        src;
      logic [WORD_SIZE-1:0] data;
   } entry_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NL-1:0]        my_pe_index = 4'd3;
   logic                 xc_valid = 1'b0;
   logic [WORD_SIZE-1:0] xc_data = '0;
   logic [NL-1:0]        xc_src_pe_index = '0;
   logic [NL-1:0]        xc_dest_pe_index = '0;
   logic                 pe_valid;
   logic                 pe_ready = 1'b0;
   logic [WORD_SIZE-1:0] pe_data;
   logic [NL-1:0]        pe_src_pe_index;
   logic [LVL_W-1:0]     fifo_level;
   logic                 overflow;
`ifdef PE_RX_DROP_CNT_EN
   logic [CNT_W-1:0]     drop_count;
`endif

   pe_xconnect_rx #(
      .WORD_SIZE (WORD_SIZE),
      .NOF_PES   (NOF_PES),
      .FIFO_DEPTH(FIFO_DEPTH)
`ifdef PE_RX_DROP_CNT_EN
      ,.CNT_W    (CNT_W)
`endif
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .my_pe_index     (my_pe_index),
      .xc_valid        (xc_valid),
      .xc_data         (xc_data),
      .xc_src_pe_index (xc_src_pe_index),
      .xc_dest_pe_index(xc_dest_pe_index),
      .pe_valid        (pe_valid),
      .pe_ready        (pe_ready),
      .pe_data         (pe_data),
      .pe_src_pe_index (pe_src_pe_index),
      .fifo_level      (fifo_level),
      .overflow        (overflow)
`ifdef PE_RX_DROP_CNT_EN
      ,.drop_count     (drop_count)
`endif
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_pops   = 0;
   bit     armed    = 1'b0;
   entry_t sb[$];
   bit     m_ovf    = 1'b0;
   int     m_drops  = 0;

   // Reference model: an unbounded queue capped at FIFO_DEPTH, sampled mid-cycle.
   always @(negedge clk) begin
      if (armed) begin
         entry_t head;
         bit     m_pop;
         n_checks++;
         if (pe_valid !== (sb.size() != 0))
            $display("FAIL sb_valid: got %b want %b at %0t", pe_valid, sb.size() != 0, $time);
         else n_pass++;
         n_checks++;
         if (32'(fifo_level) !== sb.size())
            $display("FAIL sb_level: got %0d want %0d at %0t", fifo_level, sb.size(), $time);
         else n_pass++;
         n_checks++;
         if (overflow !== m_ovf)
            $display("FAIL sb_overflow: got %b want %b at %0t", overflow, m_ovf, $time);
         else n_pass++;
`ifdef PE_RX_DROP_CNT_EN
         n_checks++;
         if (32'(drop_count) !== m_drops)
            $display("FAIL sb_drop_count: got %0d want %0d at %0t", drop_count, m_drops, $time);
         else n_pass++;
`endif
         m_pop = rst && (sb.size() != 0) && pe_ready;
         if (m_pop) begin
            head = sb.pop_front();
            n_pops++;
            n_checks++;
            if (pe_data !== head.data || pe_src_pe_index !== head.src)
               $display("FAIL sb_head: got src %0d data %h want src %0d data %h",
                        pe_src_pe_index, pe_data[31:0], head.src, head.data[31:0]);
            else n_pass++;
         end
         if (!rst) begin
            sb.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
         end else if (xc_valid && xc_dest_pe_index == my_pe_index) begin
            if (sb.size() < FIFO_DEPTH)
               sb.push_back('{src: xc_src_pe_index, data: xc_data});
            else begin
               m_ovf = 1'b1;
               if (m_drops < (1 << 16) - 1) m_drops++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [NL-1:0] dest, input logic [NL-1:0] src,
                        input logic [WORD_SIZE-1:0] d);
      xc_valid         = v;
      xc_dest_pe_index = dest;
      xc_src_pe_index  = src;
      xc_data          = d;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, '0);
      pe_ready = 1'b0;
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      n_checks++;
      if (pe_valid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0)
         $display("FAIL reset_ctrl: valid %b level %0d ovf %b want 0 0 0", pe_valid, fifo_level, overflow);
      else n_pass++;
      n_checks++;
      if (pe_data !== '0 || pe_src_pe_index !== '0)
         $display("FAIL reset_head: data %h src %0d want 0 0", pe_data[31:0], pe_src_pe_index);
      else n_pass++;
      armed = 1'b1;
      rst = 1'b1;
   endtask

   task automatic test_single();
      logic [WORD_SIZE-1:0] a5;
      a5 = {32{8'hA5}};
      drive(1'b1, 4'd3, 4'd5, a5);
      #1;
      n_checks++;
      if (pe_valid !== 1'b0)
         $display("FAIL single_nobypass: valid %b want 0", pe_valid);
      else n_pass++;
      step();
      drive(1'b0, '0, '0, '0);
      n_checks++;
      if (pe_valid !== 1'b1 || pe_data !== a5 || pe_src_pe_index !== 4'd5 || fifo_level !== 3'd1)
         $display("FAIL single_head: valid %b data %h src %0d level %0d want 1 a5a5a5a5 5 1",
                  pe_valid, pe_data[31:0], pe_src_pe_index, fifo_level);
      else n_pass++;
      pe_ready = 1'b1;
      step();
      pe_ready = 1'b0;
      n_checks++;
      if (pe_valid !== 1'b0 || fifo_level !== 3'd0)
         $display("FAIL single_pop: valid %b level %0d want 0 0", pe_valid, fifo_level);
      else n_pass++;
   endtask

   task automatic test_filter();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 4'd7, 4'(i), WORD_SIZE'(i + 100));
         pe_ready = i[0];
         step();
         n_checks++;
         if (pe_valid !== 1'b0)
            $display("FAIL filter_valid: word %0d valid %b want 0", i, pe_valid);
         else n_pass++;
      end
      drive(1'b0, '0, '0, '0);
      pe_ready = 1'b0;
      n_checks++;
      if (fifo_level !== 3'd0 || overflow !== 1'b0)
         $display("FAIL filter_state: level %0d ovf %b want 0 0", fifo_level, overflow);
      else n_pass++;
`ifdef PE_RX_DROP_CNT_EN
      n_checks++;
      if (drop_count !== '0)
         $display("FAIL filter_drops: got %0d want 0", drop_count);
      else n_pass++;
`endif
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 4'd3, 4'(i + 8), WORD_SIZE'(i));
         step();
      end
      drive(1'b0, '0, '0, '0);
      step();
      n_checks++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1 || pe_data !== WORD_SIZE'(1))
         $display("FAIL ovf_state: level %0d ovf %b head %0d want 4 1 1", fifo_level, overflow, pe_data[31:0]);
      else n_pass++;
`ifdef PE_RX_DROP_CNT_EN
      n_checks++;
      if (drop_count !== CNT_W'(2))
         $display("FAIL ovf_drops: got %0d want 2", drop_count);
      else n_pass++;
`endif
      pe_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (pe_data !== WORD_SIZE'(k) || pe_src_pe_index !== 4'(k + 8))
            $display("FAIL ovf_drain: got %0d src %0d want %0d src %0d", pe_data[31:0], pe_src_pe_index, k, k + 8);
         else n_pass++;
         step();
      end
      pe_ready = 1'b0;
      n_checks++;
      if (pe_valid !== 1'b0 || overflow !== 1'b1)
         $display("FAIL ovf_sticky: valid %b ovf %b want 0 1", pe_valid, overflow);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd3, 4'(i), WORD_SIZE'(32'hBEEF_0000 + i));
         step();
      end
      drive(1'b0, '0, '0, '0);
      n_checks++;
      if (fifo_level !== 3'd3)
         $display("FAIL rstmid_pre: level %0d want 3", fifo_level);
      else n_pass++;
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_checks++;
      if (pe_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 || pe_data !== '0)
         $display("FAIL rstmid_post: valid %b level %0d ovf %b data %h want 0 0 0 0",
                  pe_valid, fifo_level, overflow, pe_data[31:0]);
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'd3, 4'(i + 1), WORD_SIZE'(32'h10 + i));
         step();
      end
      drive(1'b1, 4'd3, 4'd15, WORD_SIZE'(32'h14));
      pe_ready = 1'b1;
      step();
      drive(1'b0, '0, '0, '0);
      pe_ready = 1'b0;
      n_checks++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0 || pe_data !== WORD_SIZE'(32'h11))
         $display("FAIL fullpp_state: level %0d ovf %b head %h want 4 0 11", fifo_level, overflow, pe_data[31:0]);
      else n_pass++;
      pe_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (pe_data !== WORD_SIZE'(32'h10 + k))
            $display("FAIL fullpp_order: got %h want %h", pe_data[31:0], 32'h10 + k);
         else n_pass++;
         step();
      end
      pe_ready = 1'b0;
      n_checks++;
      if (pe_valid !== 1'b0)
         $display("FAIL fullpp_empty: valid %b want 0", pe_valid);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int w;
      int pops0;
      do_reset();
      pops0 = n_pops;
      w = 0;
      for (int c = 0; c < 18; c++) begin
         pe_ready = (c % 2 == 0);
         if (c % 3 != 2) begin
            drive(1'b1, 4'd3, 4'((w * 5 + 1) % 16), {8{32'h1357_9BDF * (w + 1)}});
            w++;
         end else
            drive(1'b1, 4'd9, 4'd0, '1);
         step();
      end
      drive(1'b0, '0, '0, '0);
      pe_ready = 1'b1;
      for (int c = 0; c < 6; c++) step();
      pe_ready = 1'b0;
      n_checks++;
      if (n_pops - pops0 !== 12 || overflow !== 1'b0 || pe_valid !== 1'b0)
         $display("FAIL wrap_count: pops %0d ovf %b valid %b want 12 0 0", n_pops - pops0, overflow, pe_valid);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_filter();
      test_overflow();
      test_reset_mid();
      test_full_push_pop();
      test_wrap();
      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
